// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC multiplexed-bus transaction engine.
package rtc_pkg;

  typedef enum logic [3:0] {
    StReposo,
    StDirSetup,
    StDirPulso,
    StDirHold,
    StEspera,
    StDatSetup,
    StDatPulso,
    StDatHold,
    StFin
  } rtc_state_e;

  localparam int unsigned TShDef    = 1;
  localparam int unsigned TPulsoDef = 4;
  localparam int unsigned TGapDef   = 2;

  localparam logic StrobeIdle = 1'b1;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Request side (sequencer) and RTC bus side signals of the transaction engine.
interface rtc_bus_ctrl_if;
  logic       activa;
  logic       w;
  logic [7:0] dir;
  logic [7:0] dato_esc;
  logic       fin;
  logic       ocupado;
  logic [7:0] dato_leido;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;

  modport slave (
    input  activa, w, dir, dato_esc, ad_in,
    output fin, ocupado, dato_leido, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );

  modport master (
    output activa, w, dir, dato_esc, ad_in,
    input  fin, ocupado, dato_leido, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
  );
endinterface

// File: rtl/rtc_bus_temporizador.sv
// Phase down-counter: loads on carga, counts to zero and holds there.
module rtc_bus_temporizador #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             carga_i,
  input  logic [Width-1:0] valor_i,
  output logic             cero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (carga_i) begin
      cnt_q <= valor_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign cero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// One address+data bus cycle on the RTC multiplexed bus per accepted request.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int unsigned T_SH    = TShDef,
  parameter int unsigned T_PULSO = TPulsoDef,
  parameter int unsigned T_GAP   = TGapDef
) (
  input logic            clk,
  input logic            reset,
  rtc_bus_ctrl_if.slave  bus_io
);

  localparam int unsigned MaxDur = max3(T_SH, T_PULSO, T_GAP);
  localparam int unsigned CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;

  rtc_state_e      state_q, state_d;
  logic            w_q, w_d;
  logic [7:0]      dir_q, dir_d, dato_q, dato_d;
  logic [7:0]      dato_leido_q, dato_leido_d;
  logic [7:0]      ad_out_q, ad_out_d;
  logic            ad_oe_q, ad_oe_d;
  logic            cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, a_d_q, a_d_d;
  logic            fin_q, fin_d, ocupado_q, ocupado_d;
  logic            carga, cero;
  logic [CntW-1:0] valor;

  function automatic logic [CntW-1:0] dur_m1(rtc_state_e s);
    case (s)
      StDirSetup, StDirHold, StDatSetup, StDatHold: dur_m1 = CntW'(T_SH - 1);
      StDirPulso, StDatPulso:                       dur_m1 = CntW'(T_PULSO - 1);
      StEspera:                                     dur_m1 = CntW'(T_GAP - 1);
      default:                                      dur_m1 = '0;
    endcase
  endfunction

  rtc_bus_temporizador #(
    .Width(CntW)
  ) u_temporizador (
    .clk_i  (clk),
    .rst_i  (reset),
    .carga_i(carga),
    .valor_i(valor),
    .cero_o (cero)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    dir_d   = dir_q;
    dato_d  = dato_q;
    unique case (state_q)
      StReposo: begin
        if (bus_io.activa) begin
          state_d = StDirSetup;
          w_d     = bus_io.w;
          dir_d   = bus_io.dir;
          dato_d  = bus_io.dato_esc;
        end
      end
      StDirSetup: if (cero) state_d = StDirPulso;
      StDirPulso: if (cero) state_d = StDirHold;
      StDirHold:  if (cero) state_d = StEspera;
      StEspera:   if (cero) state_d = StDatSetup;
      StDatSetup: if (cero) state_d = StDatPulso;
      StDatPulso: if (cero) state_d = StDatHold;
      StDatHold:  if (cero) state_d = StFin;
      StFin:      state_d = StReposo;
      default:    state_d = StReposo;
    endcase
    // Every state change reloads the counter with the duration of the new state.
    carga = (state_d != state_q);
    valor = dur_m1(state_d);
  end

  // Outputs are decoded from the next state so they leave the flops together with it.
  always_comb begin
    cs_n_d    = StrobeIdle;
    rd_n_d    = StrobeIdle;
    wr_n_d    = StrobeIdle;
    a_d_d     = 1'b1;
    ad_oe_d   = 1'b0;
    ad_out_d  = 8'h00;
    fin_d     = 1'b0;
    ocupado_d = (state_d != StReposo);
    unique case (state_d)
      StDirSetup, StDirPulso, StDirHold: begin
        cs_n_d   = ~StrobeIdle;
        a_d_d    = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = dir_d;
        if (state_d == StDirPulso) wr_n_d = ~StrobeIdle;
      end
      StDatSetup, StDatPulso, StDatHold: begin
        cs_n_d   = ~StrobeIdle;
        ad_oe_d  = w_d;
        ad_out_d = w_d ? dato_d : 8'h00;
        if (state_d == StDatPulso) begin
          if (w_d) wr_n_d = ~StrobeIdle;
          else     rd_n_d = ~StrobeIdle;
        end
      end
      StFin:   fin_d = 1'b1;
      default: ;
    endcase
    dato_leido_d = (state_q == StDatPulso && cero && !w_q) ? bus_io.ad_in : dato_leido_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StReposo;
      w_q          <= 1'b0;
      dir_q        <= 8'h00;
      dato_q       <= 8'h00;
      dato_leido_q <= 8'h00;
      ad_out_q     <= 8'h00;
      ad_oe_q      <= 1'b0;
      cs_n_q       <= StrobeIdle;
      rd_n_q       <= StrobeIdle;
      wr_n_q       <= StrobeIdle;
      a_d_q        <= 1'b1;
      fin_q        <= 1'b0;
      ocupado_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      dir_q        <= dir_d;
      dato_q       <= dato_d;
      dato_leido_q <= dato_leido_d;
      ad_out_q     <= ad_out_d;
      ad_oe_q      <= ad_oe_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      a_d_q        <= a_d_d;
      fin_q        <= fin_d;
      ocupado_q    <= ocupado_d;
    end
  end

  assign bus_io.fin        = fin_q;
  assign bus_io.ocupado    = ocupado_q;
  assign bus_io.dato_leido = dato_leido_q;
  assign bus_io.ad_out     = ad_out_q;
  assign bus_io.ad_oe      = ad_oe_q;
  assign bus_io.cs_n       = cs_n_q;
  assign bus_io.rd_n       = rd_n_q;
  assign bus_io.wr_n       = wr_n_q;
  assign bus_io.a_d        = a_d_q;

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Low-level bus transaction engine for the RTC chip's multiplexed address/data bus. It sits directly below the `lectura` and `escritura` sequencers, which request one register access at a time through `activa`, `w` and `dir_out`. For each request it generates one complete bus cycle: an address phase followed by a data phase. It answers with a one-cycle `fin` and, for reads, the captured register byte.

## Interface
Parameters:
- `T_SH`, 1: setup/hold cycles around each strobe (≥1)
- `T_PULSO`, 4: strobe low width in cycles (≥1)
- `T_GAP`, 2: idle cycles between address and data phase (≥1)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `activa`  in  1  request strobe, level-sampled
- `w`  in  1  1 = write, 0 = read
- `dir`  in  8  RTC register address
- `dato_esc`  in  8  write data
- `fin`  out  1  one-cycle transaction-done pulse
- `ocupado`  out  1  high from acceptance through the `fin` cycle
- `dato_leido`  out  8  last byte read
- `ad_out`  out  8  bus drive value
- `ad_oe`  out  1  bus output enable (1 = drive)
- `ad_in`  in  8  bus sample value
- `cs_n`, `rd_n`, `wr_n`  out  1 each  active-low chip select and strobes
- `a_d`  out  1  0 = address phase, 1 = data phase

## Operation
- Reset and idle values:
  - `cs_n`, `rd_n`, `wr_n` = 1; `a_d` = 1; `ad_oe` = 0.
  - `ad_out` = 0x00; `dato_leido` = 0x00; `fin` = 0; `ocupado` = 0.
- FSM states: REPOSO → DIR_SETUP(T_SH) → DIR_PULSO(T_PULSO) → DIR_HOLD(T_SH) → ESPERA(T_GAP) → DAT_SETUP(T_SH) → DAT_PULSO(T_PULSO) → DAT_HOLD(T_SH) → FIN(1) → REPOSO.
- Acceptance: `activa`=1 in REPOSO. `w`, `dir` and `dato_esc` are latched at the accepting edge. Input changes after that edge are ignored until REPOSO.
- Address phase (DIR_*):
  - `a_d` = 0, `ad_oe` = 1, `ad_out` = latched `dir`, `cs_n` = 0.
  - `wr_n` = 0 only in DIR_PULSO. The address is always written with WR.
- ESPERA: `cs_n` = 1, `a_d` = 1, `ad_oe` = 0.
- Data phase (DAT_*): `a_d` = 1, `cs_n` = 0.
  - Write: `ad_oe` = 1, `ad_out` = latched `dato_esc`, `wr_n` = 0 in DAT_PULSO.
  - Read: `ad_oe` = 0, `rd_n` = 0 in DAT_PULSO. `ad_in` is captured into `dato_leido` on the edge that leaves DAT_PULSO.
- FIN: `fin` = 1 for exactly one cycle. All bus outputs return to idle values.
- `dato_leido` holds its value until the next read capture. Writes never modify it.
- `rd_n` and `wr_n` are never low simultaneously. `ad_oe` = 1 never coincides with `rd_n` = 0.
- `activa` still high in REPOSO after FIN starts a new transaction. There is a minimum of one REPOSO cycle between transactions.

## Timing
- All outputs are registered and glitch-free.
- Latency: `activa` accepted at edge E0 → `fin` high during the cycle starting at E0 + 4·T_SH + 2·T_PULSO + T_GAP. With defaults this is E0+14.
- Strobe edges:
  - Strobes fall T_SH cycles after `a_d`/`ad_out`/`cs_n` are set up.
  - Strobes rise T_SH cycles before those change.
- Phase counter: width sized for max(T_SH, T_PULSO, T_GAP).
  - Reloads with (duration−1) on each state entry.
  - The state advances when the counter reads 0.
- Reset mid-transaction: immediate return to idle values. No `fin` is produced and `dato_leido` is unchanged, apart from the reset clearing it to 0x00.
- `activa` while `ocupado` = 1 is ignored. It is neither queued nor counted.

## Structure
- Package `rtc_pkg`:
  - FSM state encoding.
  - Default timing constants T_SH/T_PULSO/T_GAP.
  - Strobe idle level constant.
- Sub-module `rtc_bus_temporizador`: down-counter with `carga`, `valor` and `cero` signals, used for all phase durations.

## Test plan
- Read: `dir`=0x03, `w`=0, `activa` pulsed one cycle, `ad_in`=0x5A during DAT_PULSO. Expect:
  - `fin` exactly 14 cycles after acceptance, `dato_leido`=0x5A.
  - `rd_n` low 4 cycles, `wr_n` low only in the address phase.
- Write: `dir`=0x04, `dato_esc`=0x21, `w`=1. Expect:
  - `ad_out`=0x04 with `a_d`=0 during the first `wr_n` pulse.
  - `ad_out`=0x21 with `a_d`=1 during the second `wr_n` pulse.
  - `ad_oe`=1 throughout both phases; `dato_leido` unchanged.
- Back-to-back: `activa` held high for 40 cycles. Expect:
  - Two complete transactions, `fin` at cycles 14 and 30.
  - Exactly one idle cycle between them.
- Input change mid-transaction: `dir` changed from 0x03 to 0x07 at cycle 3 of a read. Expect the data phase still uses 0x03 and the bus never shows 0x07.
- Reset during DAT_PULSO. Expect:
  - All strobes high, `ocupado`=0, `dato_leido`=0x00 within the reset cycle.
  - No `fin` is produced.
- Protocol checker assertions run across all tests:
  - Never `rd_n`=`wr_n`=0.
  - Never `ad_oe`=1 with `rd_n`=0.
  - `fin` width is always one cycle.
